pipe_stage_reg: RTL

Parametrised inter-stage pipeline register for the 5-stage MIPS core. It replaces the fixed per-stage registers (D/E, E/M, M/W) with one block that carries a valid bit, an instruction, a PC, NDATA 32-bit data channels, a destination register and a hazard Tnew countdown. It adds hazard-unit stall (hold) and flush (bubble insertion). The block sits between any two adjacent stages; the hazard unit drives stall and flush.

---
 rtl/pipe_pkg.sv | 12 +
 rtl/pipe_stage_reg.sv | 76 +++++++
 2 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline constants and helpers for the inter-stage registers and hazard unit.
package pipe_pkg;
  localparam logic [31:0] NOP              = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
  localparam int          PIPE_TNEW_W      = 3;

  // Saturating decrement; callers zero-extend a TNEW_W-bit value and truncate
  // the result back, so any Tnew width works and the value never wraps.
  function automatic logic [31:0] satdec(input logic [31:0] x);
    return (x == 32'd0) ? 32'd0 : x - 32'd1;
  endfunction
endpackage

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: valid/instr/pc/data/dst/Tnew with hazard stall and flush.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int          NDATA     = 2,
  parameter int          TNEW_W    = PIPE_TNEW_W,
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter bit          STALL_DEC = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [31:0]           in_instr,
  input  logic [31:0]           in_pc,
  input  logic [NDATA*32-1:0]   in_data,
  input  logic [4:0]            in_dst,
  input  logic [TNEW_W-1:0]     in_tnew,
  output logic                  out_valid,
  output logic [31:0]           out_instr,
  output logic [31:0]           out_pc,
  output logic [NDATA*32-1:0]   out_data,
  output logic [4:0]            out_dst,
  output logic [TNEW_W-1:0]     out_tnew
);
  // Declaration initialisers give the reset image from time zero.
  logic              r_valid = 1'b0;
  logic [31:0]       r_instr = NOP;
  logic [31:0]       r_pc    = RESET_PC;
  logic [4:0]        r_dst   = 5'd0;
  logic [TNEW_W-1:0] r_tnew  = '0;

  // Invalid slots and $0 writes never create a forwarding/hazard target.
  logic w_live;
  assign w_live = in_valid && (in_dst != 5'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_instr <= NOP;
      r_pc    <= RESET_PC;
      r_dst   <= 5'd0;
      r_tnew  <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_instr <= NOP;
      r_pc    <= in_pc;
      r_dst   <= 5'd0;
      r_tnew  <= '0;
    end else if (stall) begin
      if (STALL_DEC) r_tnew <= TNEW_W'(satdec(32'(r_tnew)));
    end else begin
      r_valid <= in_valid;
      r_instr <= in_instr;
      r_pc    <= in_pc;
      r_dst   <= w_live ? in_dst : 5'd0;
      r_tnew  <= w_live ? TNEW_W'(satdec(32'(in_tnew))) : '0;
    end
  end

  for (genvar k = 0; k < NDATA; k++) begin : g_ch
    logic [31:0] r_ch = 32'd0;
    always_ff @(posedge clk) begin
      if (reset || flush) r_ch <= 32'd0;
      else if (!stall)    r_ch <= in_data[32*k +: 32];
    end
    assign out_data[32*k +: 32] = r_ch;
  end

  assign out_valid = r_valid;
  assign out_instr = r_instr;
  assign out_pc    = r_pc;
  assign out_dst   = r_dst;
  assign out_tnew  = r_tnew;
endmodule
